// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Access codes, FSM state encoding and decode helpers for dmem_access_ctrl
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [3:0] c_acc_lw  = 4'b0001;
    localparam logic [3:0] c_acc_lh  = 4'b0010;
    localparam logic [3:0] c_acc_lb  = 4'b0011;
    localparam logic [3:0] c_acc_lhu = 4'b0100;
    localparam logic [3:0] c_acc_lbu = 4'b0101;
    localparam logic [3:0] c_acc_sw  = 4'b1001;
    localparam logic [3:0] c_acc_sh  = 4'b1010;
    localparam logic [3:0] c_acc_sb  = 4'b1011;

    localparam int C_STORE_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RMW  = 3'd2,
        ST_DBG  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic acc_defined(input logic [3:0] acc);
        case (acc)
            c_acc_lw, c_acc_lh, c_acc_lb, c_acc_lhu, c_acc_lbu,
            c_acc_sw, c_acc_sh, c_acc_sb: acc_defined = 1'b1;
            default:                      acc_defined = 1'b0;
        endcase
    endfunction

    // Byte accesses and undefined codes never fault on alignment.
    function automatic logic acc_aligned(input logic [3:0] acc, input logic [1:0] off);
        case (acc)
            c_acc_lw, c_acc_sw:           acc_aligned = (off == 2'b00);
            c_acc_lh, c_acc_lhu, c_acc_sh: acc_aligned = ~off[0];
            default:                      acc_aligned = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_fmt.sv
`default_nettype none
// ============================================================================
// Module   : dmem_fmt
// Purpose  : Load lane extract/extend and sub-word store merge (combinational)
// Revision : 1.0
// ============================================================================
module dmem_fmt
    import dmem_pkg::*;
(
    input  logic [3:0]  access,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = rdata[{byte_off, 3'b000} +: 8];
        w_half    = byte_off[1] ? rdata[31:16] : rdata[15:0];
        load_data = '0;
        case (access)
            c_acc_lw:  load_data = rdata;
            c_acc_lh:  load_data = {{16{w_half[15]}}, w_half};
            c_acc_lb:  load_data = {{24{w_byte[7]}}, w_byte};
            c_acc_lhu: load_data = {16'h0000, w_half};
            c_acc_lbu: load_data = {24'h000000, w_byte};
            default:   load_data = '0;
        endcase

        store_data = rdata;
        case (access)
            c_acc_sw: store_data = wdata;
            c_acc_sh: begin
                if (byte_off[1]) store_data[31:16] = wdata[15:0];
                else             store_data[15:0]  = wdata[15:0];
            end
            c_acc_sb: store_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
            default:  store_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Purpose  : MEM-stage load/store sequencer with sub-word RMW and debug read port
// Revision : 1.0
// ============================================================================
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_access,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misaligned,
    input  logic              dbg_re,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_valid,
    output logic [31:0]       dbg_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_access;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_is_dbg;
    logic              r_misaligned;
    logic [31:0]       r_resp_rdata;
    logic [31:0]       r_dbg_rdata;
    logic [31:0]       w_load_data;
    logic [31:0]       w_store_data;
    logic              w_req_defined;
    logic              w_req_aligned;
    logic              w_accept;
    logic              w_dbg_grant;
    logic              w_mem_en;
    logic              w_mem_we;
    logic              w_unused;

    dmem_fmt u_fmt (
        .access     (r_access),
        .byte_off   (r_addr[1:0]),
        .rdata      (mem_rdata),
        .wdata      (r_wdata),
        .load_data  (w_load_data),
        .store_data (w_store_data)
    );

    assign w_req_defined = acc_defined(req_access);
    assign w_req_aligned = acc_aligned(req_access, req_addr[1:0]);
    assign w_accept      = (r_state == ST_IDLE) && req_valid;
    assign w_dbg_grant   = (r_state == ST_IDLE) && !req_valid && dbg_re;
    assign w_unused      = ^req_addr[31:ADDR_W+2];

    always_comb begin
        w_state_nxt = r_state;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        mem_addr    = r_addr[ADDR_W+1:2];
        mem_wdata   = w_store_data;
        case (r_state)
            ST_IDLE: begin
                mem_addr  = req_addr[ADDR_W+1:2];
                mem_wdata = req_wdata;
                if (req_valid) begin
                    w_state_nxt = ST_DONE;
                    if (w_req_defined && w_req_aligned) begin
                        w_mem_en = 1'b1;
                        if (req_access == c_acc_sw)      w_mem_we    = 1'b1;
                        else if (req_access[C_STORE_BIT]) w_state_nxt = ST_RMW;
                        else                             w_state_nxt = ST_LOAD;
                    end
                end else if (dbg_re) begin
                    w_mem_en    = 1'b1;
                    mem_addr    = dbg_addr;
                    w_state_nxt = ST_DBG;
                end
            end
            ST_LOAD: w_state_nxt = ST_DONE;
            ST_RMW: begin
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DBG:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Gating with rstn kills a pending RMW write the moment reset asserts.
    assign mem_en          = w_mem_en & rstn;
    assign mem_we          = w_mem_we & rstn;
    assign req_ready       = rstn && (r_state == ST_IDLE);
    assign resp_valid      = (r_state == ST_DONE) && !r_is_dbg;
    assign dbg_valid       = (r_state == ST_DONE) && r_is_dbg;
    assign resp_misaligned = resp_valid && r_misaligned;
    assign resp_rdata      = r_resp_rdata;
    assign dbg_rdata       = r_dbg_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_access     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_dbg     <= 1'b0;
            r_misaligned <= 1'b0;
            r_resp_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_access     <= req_access;
                r_addr       <= req_addr[ADDR_W+1:0];
                r_wdata      <= req_wdata;
                r_is_dbg     <= 1'b0;
                r_misaligned <= w_req_defined && !w_req_aligned;
                r_resp_rdata <= '0;
            end else if (w_dbg_grant) begin
                r_is_dbg <= 1'b1;
            end
            if (r_state == ST_LOAD) r_resp_rdata <= w_load_data;
            if (r_state == ST_DBG)  r_dbg_rdata  <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Purpose  : Directed self-checking bench for dmem_access_ctrl with a sync-read memory
// Revision : 1.0
// ============================================================================
module tb_dmem_access_ctrl;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_access;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_misaligned;
    logic              dbg_re;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_valid;
    logic [31:0]       dbg_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_access      (req_access),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .dbg_re          (dbg_re),
        .dbg_addr        (dbg_addr),
        .dbg_valid       (dbg_valid),
        .dbg_rdata       (dbg_rdata),
        .mem_en          (mem_en),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read-before-write.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_op(input string tag, input logic [3:0] acc, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_en, input logic exp_we,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_mis);
        int lat;
        req_valid  = 1'b1;
        req_access = acc;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " mem_en@T"}, {31'd0, mem_en}, {31'd0, exp_en});
        chk({tag, " mem_we@T"}, {31'd0, mem_we}, {31'd0, exp_we});
        tick();
        req_valid  = 1'b0;
        req_access = 4'b0011;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'hDEAD_BEEF;
        lat = 1;
        while (!resp_valid && lat < 6) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " rdata"}, resp_rdata, exp_rdata);
        chk({tag, " misaligned"}, {31'd0, resp_misaligned}, {31'd0, exp_mis});
        tick();
        req_access = 4'b0000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
    endtask

    initial begin
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_access = 4'b0000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        dbg_re     = 1'b0;
        dbg_addr   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst dbg_valid", {31'd0, dbg_valid}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst dbg_rdata", dbg_rdata, 32'd0);
        rstn = 1'b1;
        #1;
        chk("post-rst ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Seed word 4 and verify the write-through signals at accept.
        req_valid = 1'b1; req_access = 4'b1001; req_addr = 32'h10; req_wdata = 32'h8899AABB;
        #1;
        chk("sw seed mem_addr", {24'd0, mem_addr}, 32'd4);
        chk("sw seed mem_wdata", mem_wdata, 32'h8899AABB);
        req_valid = 1'b0;
        cpu_op("sw seed", 4'b1001, 32'h10, 32'h8899AABB, 1'b1, 1'b1, 1, 32'd0, 1'b0);

        cpu_op("lb 0x13",  4'b0011, 32'h13, 32'd0, 1'b1, 1'b0, 2, 32'hFFFFFF88, 1'b0);
        cpu_op("lbu 0x11", 4'b0101, 32'h11, 32'd0, 1'b1, 1'b0, 2, 32'h000000AA, 1'b0);
        cpu_op("lhu 0x12", 4'b0100, 32'h12, 32'd0, 1'b1, 1'b0, 2, 32'h00008899, 1'b0);
        cpu_op("lh 0x10",  4'b0010, 32'h10, 32'd0, 1'b1, 1'b0, 2, 32'hFFFFAABB, 1'b0);
        cpu_op("lw 0x10",  4'b0001, 32'h10, 32'd0, 1'b1, 1'b0, 2, 32'h8899AABB, 1'b0);

        // SB 0x12: read at T, merged write at T+1, response at T+2.
        req_valid = 1'b1; req_access = 4'b1011; req_addr = 32'h12; req_wdata = 32'h12345655;
        #1;
        chk("sb T mem_en", {31'd0, mem_en}, 32'd1);
        chk("sb T mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF;
        chk("sb T+1 mem_we", {31'd0, mem_we}, 32'd1);
        chk("sb T+1 mem_wdata", mem_wdata, 32'h8855AABB);
        chk("sb T+1 mem_addr", {24'd0, mem_addr}, 32'd4);
        chk("sb T+1 resp_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("sb T+2 resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("sb T+2 rdata", resp_rdata, 32'd0);
        tick();
        cpu_op("lw after sb", 4'b0001, 32'h10, 32'd0, 1'b1, 1'b0, 2, 32'h8855AABB, 1'b0);
        cpu_op("sh 0x12", 4'b1010, 32'h12, 32'h1234, 1'b1, 1'b0, 2, 32'd0, 1'b0);
        cpu_op("lw after sh", 4'b0001, 32'h10, 32'd0, 1'b1, 1'b0, 2, 32'h1234AABB, 1'b0);

        cpu_op("sw 0x11 mis", 4'b1001, 32'h11, 32'h5555_5555, 1'b0, 1'b0, 1, 32'd0, 1'b1);
        cpu_op("lh 0x13 mis", 4'b0010, 32'h13, 32'd0, 1'b0, 1'b0, 1, 32'd0, 1'b1);
        cpu_op("noop 0000", 4'b0000, 32'h10, 32'd0, 1'b0, 1'b0, 1, 32'd0, 1'b0);
        cpu_op("lw unchanged", 4'b0001, 32'h10, 32'd0, 1'b1, 1'b0, 2, 32'h1234AABB, 1'b0);

        // CPU and debug request together: CPU wins, debug follows.
        req_valid = 1'b1; req_access = 4'b0001; req_addr = 32'h10;
        dbg_re = 1'b1; dbg_addr = 8'd4;
        #1;
        chk("arb cpu mem_en", {31'd0, mem_en}, 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("arb T+1 ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("arb cpu resp", {31'd0, resp_valid}, 32'd1);
        chk("arb cpu rdata", resp_rdata, 32'h1234AABB);
        chk("arb no dbg yet", {31'd0, dbg_valid}, 32'd0);
        tick();
        chk("arb dbg grant en", {31'd0, mem_en}, 32'd1);
        chk("arb dbg grant addr", {24'd0, mem_addr}, 32'd4);
        tick();
        dbg_re = 1'b0;
        req_valid = 1'b1; req_access = 4'b1001; req_addr = 32'h20; req_wdata = 32'h1;
        #1;
        chk("dbg busy ready", {31'd0, req_ready}, 32'd0);
        chk("dbg busy mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("dbg_valid", {31'd0, dbg_valid}, 32'd1);
        chk("dbg_rdata", dbg_rdata, 32'h1234AABB);
        chk("dbg no resp", {31'd0, resp_valid}, 32'd0);
        chk("dbg done ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("sw1 ready", {31'd0, req_ready}, 32'd1);
        chk("sw1 mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw1 mem_addr", {24'd0, mem_addr}, 32'd8);
        chk("sw1 mem_wdata", mem_wdata, 32'h1);
        tick();
        req_wdata = 32'h2;
        #1;
        chk("sw1 resp", {31'd0, resp_valid}, 32'd1);
        chk("sw gap mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        chk("sw2 mem_we", {31'd0, mem_we}, 32'd1);
        chk("sw2 mem_wdata", mem_wdata, 32'h2);
        tick();
        req_valid = 1'b0;
        chk("sw2 resp", {31'd0, resp_valid}, 32'd1);
        tick();
        cpu_op("lw 0x20", 4'b0001, 32'h20, 32'd0, 1'b1, 1'b0, 2, 32'h2, 1'b0);

        // Reset asserted while the RMW write is pending.
        req_valid = 1'b1; req_access = 4'b1011; req_addr = 32'h10; req_wdata = 32'h77;
        #1;
        tick();
        req_valid = 1'b0;
        chk("rmw pre-rst mem_we", {31'd0, mem_we}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rmw rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rmw rst mem_en", {31'd0, mem_en}, 32'd0);
        chk("rmw rst ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("rmw rst no resp", {31'd0, resp_valid}, 32'd0);
        rstn = 1'b1;
        #1;
        chk("rst release ready", {31'd0, req_ready}, 32'd1);
        tick();
        cpu_op("lw after rst", 4'b0001, 32'h10, 32'd0, 1'b1, 1'b0, 2, 32'h1234AABB, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
